// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Brief    : Shared types and constants for the calculator autodriver slice.
//            UNDO states exist only with CALC_AUTODRIVER_ABORT_EN defined.
// Revision : 1.0
// ============================================================================
package calc_pkg;

    localparam int C_DATA_W = 16;
    localparam int C_FLAG_W = 4;
    localparam int C_STEP_W = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_OR  = 2'd2,
        OP_AND = 2'd3
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_PRESS      = 3'd2,
        ST_WAIT       = 3'd3,
        ST_RELEASE    = 3'd4
`ifdef CALC_AUTODRIVER_ABORT_EN
        ,
        ST_UNDO_SETUP = 3'd5,
        ST_UNDO_PRESS = 3'd6
`endif
    } state_t;

    typedef enum logic [1:0] {
        PG_IDLE = 2'd0,
        PG_GAP  = 2'd1,
        PG_HOLD = 2'd2
    } press_phase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_autodriver_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_autodriver_if
// Brief    : Request, calculator-button and result signals of the autodriver.
// Revision : 1.0
// ============================================================================
interface calc_autodriver_if;
    import calc_pkg::*;

    logic                start;
    logic [C_DATA_W-1:0] op_a;
    logic [C_DATA_W-1:0] op_b;
    logic [1:0]          opcode;
    logic                abort;
    logic [C_DATA_W-1:0] display;
    logic [C_FLAG_W-1:0] flags;
    logic                enter;
    logic                undo;
    logic [C_DATA_W-1:0] value;
    logic                busy;
    logic                done;
    logic                aborted;
    logic [C_DATA_W-1:0] result;
    logic [C_FLAG_W-1:0] result_flags;

    modport master (
        input  start, op_a, op_b, opcode, abort, display, flags,
        output enter, undo, value, busy, done, aborted, result, result_flags
    );

    modport slave (
        output start, op_a, op_b, opcode, abort, display, flags,
        input  enter, undo, value, busy, done, aborted, result, result_flags
    );
endinterface : calc_autodriver_if
`default_nettype wire

// File: rtl/calc_press_gen.sv
`default_nettype none
// ============================================================================
// Module   : calc_press_gen
// Brief    : One button press: gap cycles low, then hold cycles high. A go
//            pulse (re)starts the gap; ack marks the last hold cycle.
// Revision : 1.0
// ============================================================================
module calc_press_gen
    import calc_pkg::*;
#(
    parameter int C_GAP_CYCLES  = 16,
    parameter int C_HOLD_CYCLES = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic go,
    output logic      button,
    output logic      gap_end,
    output logic      ack
);

    localparam int C_CNT_W = $clog2(max3(C_GAP_CYCLES, C_HOLD_CYCLES, 1) + 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LOAD  = C_CNT_W'(C_GAP_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_HOLD_LOAD = C_CNT_W'(C_HOLD_CYCLES - 1);

    press_phase_t        r_phase, w_phase_nxt;
    logic [C_CNT_W-1:0]  r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PG_IDLE;
            r_cnt   <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        button      = 1'b0;
        gap_end     = 1'b0;
        ack         = 1'b0;
        case (r_phase)
            PG_GAP: begin
                if (r_cnt == '0) begin
                    gap_end     = 1'b1;
                    w_phase_nxt = PG_HOLD;
                    w_cnt_nxt   = C_HOLD_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            PG_HOLD: begin
                button = 1'b1;
                if (r_cnt == '0) begin
                    ack         = 1'b1;
                    w_phase_nxt = PG_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: ;
        endcase
        // A new go always wins so the owner can chain presses back to back.
        if (go) begin
            w_phase_nxt = PG_GAP;
            w_cnt_nxt   = C_GAP_LOAD;
        end
    end

endmodule : calc_press_gen
`default_nettype wire

// File: rtl/calc_autodriver.sv
`default_nettype none
// ============================================================================
// Module   : calc_autodriver
// Brief    : Plays operand A, operand B, opcode and a final enter into the
//            calculator, capturing display/flags before the final press.
//            Abort/undo support compiled in with CALC_AUTODRIVER_ABORT_EN.
// Revision : 1.0
// ============================================================================
module calc_autodriver
    import calc_pkg::*;
#(
    parameter int C_HOLD_CYCLES   = 16,
    parameter int C_GAP_CYCLES    = 16,
    parameter int C_SETTLE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    calc_autodriver_if.master  bus
);

    localparam int C_TMR_W = $clog2(max3(C_GAP_CYCLES, C_HOLD_CYCLES, C_SETTLE_CYCLES) + 1);
    localparam logic [C_TMR_W-1:0] C_SETTLE_LOAD = C_TMR_W'(C_SETTLE_CYCLES - 1);
    localparam logic [C_TMR_W-1:0] C_GAP_LOAD    = C_TMR_W'(C_GAP_CYCLES - 1);

    state_t                r_state, w_state_nxt;
    logic [C_STEP_W-1:0]   r_step, w_step_nxt;
    logic [C_TMR_W-1:0]    r_timer, w_timer_nxt;
    logic [C_DATA_W-1:0]   r_op_a, r_op_b;
    opcode_t               r_opcode;
    logic                  r_done, w_done_nxt;
    logic                  r_aborted, w_aborted_nxt;
    logic [C_DATA_W-1:0]   r_result;
    logic [C_FLAG_W-1:0]   r_result_flags;
    logic                  w_accept, w_capture, w_go;
    logic                  w_button, w_gap_end, w_ack;

`ifdef CALC_AUTODRIVER_ABORT_EN
    logic                  r_abort_pend, w_pend_nxt;
    logic                  w_abort_req;
    assign w_abort_req = r_abort_pend | (bus.abort & (r_step < 3'd3));
`else
    logic                  w_unused_abort;
    assign w_unused_abort = bus.abort;
`endif

    calc_press_gen #(
        .C_GAP_CYCLES  (C_GAP_CYCLES),
        .C_HOLD_CYCLES (C_HOLD_CYCLES)
    ) u_press_gen (
        .clk     (clk),
        .rst     (rst),
        .go      (w_go),
        .button  (w_button),
        .gap_end (w_gap_end),
        .ack     (w_ack)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_step         <= '0;
            r_timer        <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_opcode       <= OP_ADD;
            r_done         <= 1'b0;
            r_aborted      <= 1'b0;
            r_result       <= '0;
            r_result_flags <= '0;
`ifdef CALC_AUTODRIVER_ABORT_EN
            r_abort_pend   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_step    <= w_step_nxt;
            r_timer   <= w_timer_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
`ifdef CALC_AUTODRIVER_ABORT_EN
            r_abort_pend <= w_pend_nxt;
`endif
            if (w_accept) begin
                r_op_a   <= bus.op_a;
                r_op_b   <= bus.op_b;
                r_opcode <= opcode_t'(bus.opcode);
            end
            if (w_capture) begin
                r_result       <= bus.display;
                r_result_flags <= bus.flags;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_timer_nxt   = r_timer;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_go          = 1'b0;
`ifdef CALC_AUTODRIVER_ABORT_EN
        w_pend_nxt    = r_abort_pend;
`endif
        case (r_state)
            ST_IDLE: begin
                // The done cycle is spent in IDLE but does not accept.
                if (bus.start && !r_done) begin
                    w_accept    = 1'b1;
                    w_step_nxt  = '0;
                    w_go        = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_gap_end) w_state_nxt = ST_PRESS;
            end
            ST_PRESS: begin
                if (w_ack) begin
                    w_step_nxt = r_step + 3'd1;
                    if (r_step == 3'd2) begin
                        w_state_nxt = ST_WAIT;
                        w_timer_nxt = C_SETTLE_LOAD;
                    end else if (r_step == 3'd3) begin
                        w_state_nxt = ST_RELEASE;
                        w_timer_nxt = C_GAP_LOAD;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_go        = 1'b1;
                    end
`ifdef CALC_AUTODRIVER_ABORT_EN
                    if (w_abort_req) begin
                        w_state_nxt = ST_UNDO_SETUP;
                        w_go        = 1'b1;
                        w_pend_nxt  = 1'b0;
                    end
`endif
                end
            end
            ST_WAIT: begin
                if (r_timer == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_go        = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
`ifdef CALC_AUTODRIVER_ABORT_EN
            ST_UNDO_SETUP: begin
                if (w_gap_end) w_state_nxt = ST_UNDO_PRESS;
            end
            ST_UNDO_PRESS: begin
                if (w_ack) begin
                    w_step_nxt = r_step - 3'd1;
                    if (r_step == 3'd1) begin
                        w_state_nxt   = ST_IDLE;
                        w_done_nxt    = 1'b1;
                        w_aborted_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNDO_SETUP;
                        w_go        = 1'b1;
                    end
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef CALC_AUTODRIVER_ABORT_EN
        // One undo press per completed enter press takes the calculator back.
        if (bus.abort) begin
            case (r_state)
                ST_SETUP: begin
                    if (r_step == 3'd0) begin
                        w_state_nxt   = ST_IDLE;
                        w_done_nxt    = 1'b1;
                        w_aborted_nxt = 1'b1;
                        w_go          = 1'b0;
                    end else if (r_step < 3'd3) begin
                        w_state_nxt = ST_UNDO_SETUP;
                        w_go        = 1'b1;
                    end
                end
                ST_WAIT: begin
                    w_state_nxt = ST_UNDO_SETUP;
                    w_go        = 1'b1;
                    w_capture   = 1'b0;
                    w_timer_nxt = r_timer;
                end
                ST_PRESS: begin
                    if ((r_step < 3'd3) && !w_ack) w_pend_nxt = 1'b1;
                end
                default: ;
            endcase
        end
`endif
    end

    always_comb begin
        bus.value = '0;
        if ((r_state == ST_SETUP) || (r_state == ST_PRESS)) begin
            case (r_step)
                3'd0:    bus.value = r_op_a;
                3'd1:    bus.value = r_op_b;
                3'd2:    bus.value = {{(C_DATA_W-2){1'b0}}, r_opcode};
                default: bus.value = '0;
            endcase
        end
    end

    assign bus.enter        = (r_state == ST_PRESS) & w_button;
`ifdef CALC_AUTODRIVER_ABORT_EN
    assign bus.undo         = (r_state == ST_UNDO_PRESS) & w_button;
`else
    assign bus.undo         = 1'b0;
`endif
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.done         = r_done;
    assign bus.aborted      = r_aborted;
    assign bus.result       = r_result;
    assign bus.result_flags = r_result_flags;

endmodule : calc_autodriver
`default_nettype wire

// File: tb/tb_calc_autodriver.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_autodriver
// Brief    : Directed and random sequences against a behavioural calculator.
// Revision : 1.0
// ============================================================================
module tb_calc_autodriver;

    localparam int G = 2;
    localparam int H = 3;
    localparam int S = 2;
    localparam int T_DONE = 4 * (G + H) + S + G + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    calc_autodriver_if bus ();

    calc_autodriver #(
        .C_HOLD_CYCLES   (H),
        .C_GAP_CYCLES    (G),
        .C_SETTLE_CYCLES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    always @(posedge clk) cyc = cyc + 1;

    // {zero, negative, carry/borrow, 0} over a 16-bit result.
    function automatic logic [19:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        logic [16:0] w;
        case (op)
            2'd0:    w = {1'b0, a} + {1'b0, b};
            2'd1:    w = {1'b0, a} - {1'b0, b};
            2'd2:    w = {1'b0, a | b};
            default: w = {1'b0, a & b};
        endcase
        return {(w[15:0] == 16'd0), w[15], w[16], 1'b0, w[15:0]};
    endfunction

    // Calculator: enter edges walk A -> B -> opcode(compute) -> back to A; undo steps back.
    int          m_stage;
    logic [15:0] m_a, m_b;
    logic        m_enter_q, m_undo_q;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_stage <= 0; m_a <= '0; m_b <= '0;
            bus.display <= '0; bus.flags <= '0;
            m_enter_q <= 1'b0; m_undo_q <= 1'b0;
        end else begin
            m_enter_q <= bus.enter;
            m_undo_q  <= bus.undo;
            if (bus.enter && !m_enter_q) begin
                case (m_stage)
                    0: begin m_a <= bus.value; m_stage <= 1; end
                    1: begin m_b <= bus.value; m_stage <= 2; end
                    2: begin {bus.flags, bus.display} <= alu(m_a, m_b, bus.value[1:0]); m_stage <= 3; end
                    default: m_stage <= 0;
                endcase
            end else if (bus.undo && !m_undo_q && m_stage != 0) begin
                m_stage <= m_stage - 1;
            end
        end
    end

    // Observation of button activity, sampled on the falling edge.
    int          n_done = 0, done_at = 0, n_undo = 0, n_undo_cyc = 0, n_glitch = 0;
    logic        done_ab = 1'b0;
    int          pulse_len[$];
    logic [15:0] pulse_val[$];
    int          cur_len = 0;
    logic [15:0] cur_val = '0;
    logic        enter_p = 1'b0, undo_p = 1'b0;
    logic [15:0] value_p = '0;
    always @(negedge clk) begin
        if (bus.enter) begin
            if (!enter_p) begin cur_len = 0; cur_val = bus.value; end
            cur_len++;
        end else if (enter_p) begin
            pulse_len.push_back(cur_len);
            pulse_val.push_back(cur_val);
        end
        if (bus.undo) n_undo_cyc++;
        if (bus.undo && !undo_p) n_undo++;
        if ((bus.enter || bus.undo) && bus.value !== value_p) n_glitch++;
        if (bus.done) begin n_done++; done_at = cyc - t0; done_ab = bus.aborted; end
        enter_p = bus.enter; undo_p = bus.undo; value_p = bus.value;
    end

    int          snap_done, snap_p, snap_undo, snap_undo_cyc, snap_glitch;
    logic [15:0] last_res = '0;
    logic [3:0]  last_flags = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    // Called at a falling edge; that cycle is cycle 0 and its rising edge accepts.
    task automatic start_seq(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        bus.op_a = a; bus.op_b = b; bus.opcode = op; bus.start = 1'b1;
        t0 = cyc;
        snap_done = n_done; snap_p = pulse_len.size(); snap_undo = n_undo;
        snap_undo_cyc = n_undo_cyc; snap_glitch = n_glitch;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic finish_normal(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        logic [19:0] e;
        logic [15:0] ev [4];
        int          np;
        e = alu(a, b, op);
        ev[0] = a; ev[1] = b; ev[2] = {14'd0, op}; ev[3] = 16'd0;
        check({tag, ".busy_c1"}, bus.busy, 1);
        wait_cyc(T_DONE - 1);
        check({tag, ".busy_pre_done"}, bus.busy, 1);
        wait_cyc(T_DONE);
        check({tag, ".done"}, bus.done, 1);
        check({tag, ".busy_at_done"}, bus.busy, 0);
        check({tag, ".aborted"}, bus.aborted, 0);
        check({tag, ".result"}, bus.result, e[15:0]);
        check({tag, ".flags"}, bus.result_flags, e[19:16]);
        wait_cyc(T_DONE + 3);
        check({tag, ".done_count"}, n_done - snap_done, 1);
        np = pulse_len.size() - snap_p;
        check({tag, ".enter_pulses"}, np, 4);
        for (int i = 0; i < 4 && i < np; i++) begin
            check({tag, $sformatf(".len%0d", i)}, pulse_len[snap_p + i], H);
            check({tag, $sformatf(".val%0d", i)}, pulse_val[snap_p + i], ev[i]);
        end
        check({tag, ".glitch"}, n_glitch - snap_glitch, 0);
        check({tag, ".undo"}, n_undo - snap_undo, 0);
        check({tag, ".calc_stage"}, m_stage, 0);
        last_res = e[15:0]; last_flags = e[19:16];
    endtask

    task automatic finish_abort(input string tag, input int n_press, input int t_done);
        wait_cyc(t_done);
        check({tag, ".done"}, bus.done, 1);
        check({tag, ".aborted"}, bus.aborted, 1);
        check({tag, ".busy"}, bus.busy, 0);
        check({tag, ".result_kept"}, bus.result, last_res);
        check({tag, ".flags_kept"}, bus.result_flags, last_flags);
        wait_cyc(t_done + 3);
        check({tag, ".done_count"}, n_done - snap_done, 1);
        check({tag, ".enter_pulses"}, pulse_len.size() - snap_p, n_press);
        check({tag, ".undo_pulses"}, n_undo - snap_undo, n_press);
        check({tag, ".undo_cycles"}, n_undo_cyc - snap_undo_cyc, n_press * H);
        check({tag, ".glitch"}, n_glitch - snap_glitch, 0);
        check({tag, ".calc_stage"}, m_stage, 0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [1:0]  rop;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.opcode = '0; bus.abort = 1'b0;

        repeat (3) @(negedge clk);
        check("rst.enter", bus.enter, 0);
        check("rst.undo", bus.undo, 0);
        check("rst.value", bus.value, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check("rst.aborted", bus.aborted, 0);
        check("rst.result", bus.result, 0);
        check("rst.flags", bus.result_flags, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_seq(16'h0005, 16'h0003, 2'd0);
        finish_normal("add", 16'h0005, 16'h0003, 2'd0);

        start_seq(16'h0003, 16'h0005, 2'd1);
        finish_normal("sub", 16'h0003, 16'h0005, 2'd1);

        // Second start while busy, with op_b changed after accept.
        start_seq(16'h00F0, 16'h000F, 2'd2);
        wait_cyc(10);
        bus.op_b = 16'hABCD; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        finish_normal("restart", 16'h00F0, 16'h000F, 2'd2);

`ifdef CALC_AUTODRIVER_ABORT_EN
        // Abort in step 1's press: two enters complete, then two undos.
        start_seq(16'h1234, 16'h0042, 2'd3);
        wait_cyc(8);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        finish_abort("abort_press", 2, 4 * (G + H) + 1);

        // Abort in step 2's setup at cycle 11.
        start_seq(16'h0101, 16'h0202, 2'd0);
        wait_cyc(11);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        finish_abort("abort_setup", 2, 11 + 2 * (G + H) + 1);
`else
        bus.abort = 1'b1;
        start_seq(16'h7FFF, 16'h0001, 2'd0);
        finish_normal("abort_ignored", 16'h7FFF, 16'h0001, 2'd0);
        bus.abort = 1'b0;
`endif

        // Reset in the middle of step 1's press.
        start_seq(16'h0011, 16'h0022, 2'd0);
        wait_cyc(9);
        check("midrst.enter_before", bus.enter, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst.enter", bus.enter, 0);
        check("midrst.busy", bus.busy, 0);
        check("midrst.value", bus.value, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_seq(16'h0011, 16'h0022, 2'd0);
        finish_normal("after_rst", 16'h0011, 16'h0022, 2'd0);

        for (int n = 0; n < 6; n++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = 2'($urandom_range(0, 3));
            start_seq(ra, rb, rop);
            finish_normal($sformatf("rand%0d", n), ra, rb, rop);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_calc_autodriver
`default_nettype wire
